// File: rtl/ctrl_pkg.sv
// Shared types for the E/M/W control pipeline: stage control word, bubble value, forward selects.
package ctrl_pkg;

    localparam int CTRL_RW = 4;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef struct packed {
        logic               valid;
        logic               weD;
        logic               wdeMD;
        logic               rsWBD;
        logic               d2sED;
        logic [2:0]         aluED;
        logic               outFlag;
        logic [CTRL_RW-1:0] rd;
    } ctrl_t;

    // All-zero word: identical to the decode of opcode 0000.
    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_unit.sv
// Combinational load-use stall detection and E-stage operand-forwarding selects.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REGW     = CTRL_RW,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            validD,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    input  ctrl_t           ctrlE,
    input  logic [REGW-1:0] rs1E,
    input  logic [REGW-1:0] rs2E,
    input  ctrl_t           ctrlM,
    input  ctrl_t           ctrlW,
    output logic            stallD,
    output logic [1:0]      fwdAE,
    output logic [1:0]      fwdBE
);

    // A register address can carry a dependency unless it is the hard-wired zero register.
    function automatic logic is_src(input logic [REGW-1:0] a);
        return !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [1:0] pick(input logic m_hit, input logic w_hit);
        if (m_hit)      return FWD_M;
        else if (w_hit) return FWD_W;
        else            return FWD_RF;
    endfunction

    logic load_in_e;
    logic m_fwd_ok;
    logic w_fwd_ok;

    assign load_in_e = ctrlE.valid & ctrlE.rsWBD & ctrlE.weD & is_src(ctrlE.rd);
    assign stallD    = validD & load_in_e & ((ctrlE.rd == rs1D) | (ctrlE.rd == rs2D));

    // Loads in M have no data yet; the stall guarantees their consumer meets them in W.
    assign m_fwd_ok = ctrlM.valid & ctrlM.weD & ~ctrlM.rsWBD & is_src(ctrlM.rd);
    assign w_fwd_ok = ctrlW.valid & ctrlW.weD & is_src(ctrlW.rd);

    assign fwdAE = pick(m_fwd_ok && (ctrlM.rd == rs1E), w_fwd_ok && (ctrlW.rd == rs1E));
    assign fwdBE = pick(m_fwd_ok && (ctrlM.rd == rs2E), w_fwd_ok && (ctrlW.rd == rs2E));

    logic unused_fields;
    assign unused_fields = ^{ctrlE.wdeMD, ctrlE.d2sED, ctrlE.aluED, ctrlE.outFlag,
                             ctrlM.wdeMD, ctrlM.d2sED, ctrlM.aluED, ctrlM.outFlag,
                             ctrlW.rsWBD, ctrlW.wdeMD, ctrlW.d2sED, ctrlW.aluED, ctrlW.outFlag};

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoded control word through the E, M and W stage registers, inserting
// bubbles for load-use hazards and flushes.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REGW     = CTRL_RW,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            validD,
    input  logic            writeEnableDD,
    input  logic            writeDataEnableMD,
    input  logic            resultSelectorWBD,
    input  logic            data2SelectorED,
    input  logic [2:0]      aluControlED,
    input  logic            outFlagD,
    input  logic [REGW-1:0] rs1D,
    input  logic [REGW-1:0] rs2D,
    input  logic [REGW-1:0] rdD,
    input  logic            flushE,
    output logic            stallD,
    output logic [2:0]      aluControlE,
    output logic            data2SelectorE,
    output logic [1:0]      fwdAE,
    output logic [1:0]      fwdBE,
    output logic            writeDataEnableM,
    output logic            writeEnableW,
    output logic            resultSelectorW,
    output logic [REGW-1:0] rdW,
    output logic            outFlagW,
    output logic            validW
);

    ctrl_t           e_q, e_d;
    ctrl_t           m_q;
    ctrl_t           w_q;
    logic [REGW-1:0] rs1E_q, rs1E_d;
    logic [REGW-1:0] rs2E_q, rs2E_d;

    // validD qualifies the D bundle; stallD is the back-pressure: while it is high the
    // decode stage must present the same bundle again on the next cycle.
    always_comb begin
        e_d    = CTRL_BUBBLE;
        rs1E_d = '0;
        rs2E_d = '0;
        if (validD && !flushE && !stallD) begin
            e_d.valid   = 1'b1;
            e_d.weD     = writeEnableDD;
            e_d.wdeMD   = writeDataEnableMD;
            e_d.rsWBD   = resultSelectorWBD;
            e_d.d2sED   = data2SelectorED;
            e_d.aluED   = aluControlED;
            e_d.outFlag = outFlagD;
            e_d.rd      = rdD;
            rs1E_d      = rs1D;
            rs2E_d      = rs2D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_q    <= CTRL_BUBBLE;
            m_q    <= CTRL_BUBBLE;
            w_q    <= CTRL_BUBBLE;
            rs1E_q <= '0;
            rs2E_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= e_q;
            w_q    <= m_q;
            rs1E_q <= rs1E_d;
            rs2E_q <= rs2E_d;
        end
    end

    hazard_unit #(
        .REGW     (REGW),
        .ZERO_REG (ZERO_REG)
    ) u_hazard (
        .validD (validD),
        .rs1D   (rs1D),
        .rs2D   (rs2D),
        .ctrlE  (e_q),
        .rs1E   (rs1E_q),
        .rs2E   (rs2E_q),
        .ctrlM  (m_q),
        .ctrlW  (w_q),
        .stallD (stallD),
        .fwdAE  (fwdAE),
        .fwdBE  (fwdBE)
    );

    assign aluControlE      = e_q.aluED;
    assign data2SelectorE   = e_q.d2sED;
    assign writeDataEnableM = m_q.wdeMD;
    assign writeEnableW     = w_q.weD;
    assign resultSelectorW  = w_q.rsWBD;
    assign rdW              = w_q.rd;
    assign outFlagW         = w_q.outFlag;
    assign validW           = w_q.valid;

    logic unused_w;
    assign unused_w = ^{w_q.wdeMD, w_q.d2sED, w_q.aluED};

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Consumer end of the decode-stage control bundle. Takes the D-stage control word produced by opcode decode and carries it through the E, M and W pipeline registers.
- Inserts bubbles for load-use hazards and for external flushes.
- Generates the E-stage operand-forwarding selects.
- Sits between decode and the datapath stage registers. The datapath consumes only stage-qualified controls from this block.

Parameters:
- REGW, 4, register-address width (rs1/rs2/rd).
- ZERO_REG, 1, when 1, register address 0 is never a hazard or forwarding source.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- validD  in  1  D-stage instruction valid.
- writeEnableDD  in  1  D-stage register-file write enable.
- writeDataEnableMD  in  1  D-stage memory write enable.
- resultSelectorWBD  in  1  D-stage writeback select (1 = memory data, i.e. load).
- data2SelectorED  in  1  D-stage ALU operand-2 select (1 = immediate).
- aluControlED  in  3  D-stage ALU operation.
- outFlagD  in  1  D-stage output-port strobe.
- rs1D, rs2D  in  REGW  D-stage source register addresses.
- rdD  in  REGW  D-stage destination register address.
- flushE  in  1  external flush (taken branch); kills the instruction entering E.
- stallD  out  1  hold the F and D registers this cycle (combinational).
- aluControlE  out  3  E-stage ALU op.
- data2SelectorE  out  1  E-stage operand-2 select.
- fwdAE, fwdBE  out  2  E-stage forward select: 00 = register file, 01 = W result, 10 = M ALU result.
- writeDataEnableM  out  1  M-stage memory write enable.
- writeEnableW  out  1  W-stage register-file write enable.
- resultSelectorW  out  1  W-stage writeback select.
- rdW  out  REGW  W-stage destination register.
- outFlagW  out  1  W-stage output strobe.
- validW  out  1  W-stage valid.

Behaviour:
- Stage registers E, M and W each hold: valid, weD, wdeMD, rsWBD, d2sED, aluED[2:0], outFlag, rd. E additionally holds rs1 and rs2.
- Bubble value: valid = 0, all enables = 0, alu = 000, d2s = 0, rd/rs = 0. This is identical to the decode of opcode 0000.
- Reset (rst = 1 at an edge): E, M and W all load the bubble. After reset every output is 0: stallD = 0 and fwd = 00 follow from the bubbled registers. Reset mid-stream discards all in-flight instructions.
- Enable gating: all D-stage enables are ANDed with validD before capture. An invalid D slot enters E as a bubble.
- Load-use hazard (combinational):
  - stallD = E.valid & E.rsWBD & E.weD & (E.rd == rs1D | E.rd == rs2D) & validD.
  - When ZERO_REG = 1, a match on address 0 is excluded.
- E register update priority: rst > flushE > stallD > normal.
  - flushE or stallD: E loads the bubble.
  - Otherwise E loads the D bundle.
- M and W registers always advance: M <= E, W <= M. They are never stalled or flushed except by rst.
- Simultaneous flushE and stallD: flush wins. The bubble is still inserted, and stallD is still asserted the same cycle. The upstream flush logic overrides F/D.
- Forwarding, fwdAE (fwdBE identical, using rs2E):
  - Select 10 when M.valid & M.weD & !M.rsWBD & M.rd == rs1E (and M.rd != 0 when ZERO_REG = 1).
  - Otherwise select 01 when W.valid & W.weD & W.rd == rs1E, with the same zero exclusion.
  - Otherwise select 00. M has priority over W.
  - Loads in M never forward. The load-use stall guarantees the consumer sees the load in W.
- Latency: D to E outputs in 1 cycle, to M in 2 cycles, to W in 3 cycles.
- Stall cost: exactly 1 bubble per load-use occurrence.

Decomposition:
- ctrl_pkg holds:
  - typedef ctrl_t (valid, weD, wdeMD, rsWBD, d2sED, aluED, outFlag, rd).
  - constant CTRL_BUBBLE.
  - localparams FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
- Sub-module hazard_unit: purely combinational. Computes stallD, fwdAE and fwdBE from the D, E, M and W fields.
- Top module ctrl_pipe holds the three stage registers.

Test Plan:
- Reset: hold rst 2 cycles with validD = 1, aluControlED = 101 → all outputs 0 during reset. aluControlE = 101 one cycle after rst falls.
- Straight pipeline: issue an ALU op (weD = 1, alu = 000, rdD = 3) → writeEnableW = 1, rdW = 3 exactly 3 cycles later. validW = 1.
- Forwarding:
  - Issue add r3, then r4 = r3 + r5 the next cycle → fwdAE = 10 while the second op is in E.
  - Insert one independent op between them → fwdAE = 01.
- Load-use: issue a load (rsWBD = 1, weD = 1, rd = 2), then an op with rs2D = 2 → stallD = 1 for exactly one cycle. E shows a bubble (aluControlE = 000, valid = 0) next. The dependent op in E then has fwdBE = 01.
- Flush: assert flushE with validD = 1, writeDataEnableMD = 1 → writeDataEnableM stays 0 two cycles later. validW = 0 three cycles later.
- Zero register: ZERO_REG = 1, load to rd = 0 followed by a reader of rs1 = 0 → stallD = 0 and fwdAE = 00.
